// File: rtl/tt_sweep_capture.sv
`timescale 1ns/1ps
// Exhaustive minterm sweep of a single-output combinational netlist. It captures
// the netlist output into a truth table and scores it against a latched expected table.
module tt_sweep_capture #(
  parameter int NUM_PI = 4,
  parameter int LAT    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [(1 << NUM_PI)-1:0]   exp_tt,
  output logic [NUM_PI-1:0]          pi,
  input  logic                       po,
  output logic                       busy,
  output logic                       done,
  output logic [(1 << NUM_PI)-1:0]   tt,
  output logic                       match,
  output logic [NUM_PI:0]            mism_cnt
);

  localparam int NT = 1 << NUM_PI;
  localparam logic [3:0]        LAT_C  = 4'(LAT);
  localparam logic [NUM_PI-1:0] M_LAST = NUM_PI'(NT - 1);
  localparam logic [NUM_PI:0]   CNT_MAX = (NUM_PI + 1)'(NT);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t              state_q, state_d;
  logic [NUM_PI-1:0]   m_q, m_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [NT-1:0]       exp_q, exp_d;
  logic [NT-1:0]       tt_q, tt_d;
  logic [NUM_PI:0]     mism_q, mism_d;
  logic                match_q, match_d;
  logic [NUM_PI-1:0]   pi_q, pi_d;

  // The counter can never legitimately exceed NT; holding at NT keeps it from wrapping.
  function automatic logic [NUM_PI:0] sat_inc(input logic [NUM_PI:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    wcnt_d  = wcnt_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    mism_d  = mism_q;
    match_d = match_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          m_d     = '0;
          wcnt_d  = '0;
          exp_d   = exp_tt;
          tt_d    = '0;
          mism_d  = '0;
          match_d = 1'b0;
        end
      end
      SWEEP: begin
        if (wcnt_q != LAT_C) begin
          wcnt_d = wcnt_q + 1'b1;
        end else begin
          // po is taken straight from the netlist on the edge that closes the settle window.
          tt_d[m_q] = po;
          if (po != exp_q[m_q]) mism_d = sat_inc(mism_q);
          if (m_q == M_LAST) begin
            state_d = DONE;
            match_d = (mism_d == '0);
            m_d     = '0;
            wcnt_d  = '0;
          end else begin
            m_d    = m_q + 1'b1;
            wcnt_d = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pi_d = (state_d == SWEEP) ? m_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      wcnt_q  <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      mism_q  <= '0;
      match_q <= 1'b0;
      pi_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      wcnt_q  <= wcnt_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      mism_q  <= mism_d;
      match_q <= match_d;
      pi_q    <= pi_d;
    end
  end

  assign pi       = pi_q;
  assign busy     = (state_q == SWEEP);
  assign done     = (state_q == DONE);
  assign tt       = tt_q;
  assign match    = match_q;
  assign mism_cnt = mism_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
`timescale 1ns/1ps
// Directed bench for tt_sweep_capture: one LAT=0 instance and one LAT=2 instance
// driven from a single sequence of scenario tasks.
module tb_tt_sweep_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start0 = 1'b0;
  logic [15:0] exp_tt0 = 16'h0;
  logic [3:0]  pi0;
  logic        po0;
  logic        busy0, done0, match0;
  logic [15:0] tt0;
  logic [4:0]  mism0;
  logic        mode_zero = 1'b0;

  logic        start2 = 1'b0;
  logic [15:0] exp_tt2 = 16'h0;
  logic [3:0]  pi2;
  logic        po2_q = 1'b0;
  logic        busy2, done2, match2;
  logic [15:0] tt2;
  logic [4:0]  mism2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign po0 = mode_zero ? 1'b0 : pi0[0];
  always @(posedge clk) po2_q <= pi2[3];

  tt_sweep_capture #(.NUM_PI(4), .LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .exp_tt(exp_tt0), .pi(pi0), .po(po0),
    .busy(busy0), .done(done0), .tt(tt0), .match(match0), .mism_cnt(mism0)
  );

  tt_sweep_capture #(.NUM_PI(4), .LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .exp_tt(exp_tt2), .pi(pi2), .po(po2_q),
    .busy(busy2), .done(done2), .tt(tt2), .match(match2), .mism_cnt(mism2)
  );

  // Starts a LAT=0 sweep at the next edge; cyc returns the edge number whose following cycle shows done.
  task automatic do_sweep0(input logic [15:0] e, input logic [15:0] e_after,
                           input bit hold, output int cyc);
    exp_tt0 = e;
    start0  = 1'b1;
    @(posedge clk); #1;
    exp_tt0 = e_after;
    if (!hold) start0 = 1'b0;
    cyc = 0;
    while (done0 !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy0, done0, match0} !== 3'b000 || pi0 !== 4'h0) begin
      errors++;
      $display("FAIL reset_ctl0: busy=%b done=%b match=%b pi=%h expected 0", busy0, done0, match0, pi0);
    end
    checks++;
    if (tt0 !== 16'h0 || mism0 !== 5'd0) begin
      errors++;
      $display("FAIL reset_data0: tt=%h mism=%0d expected 0", tt0, mism0);
    end
    checks++;
    if ({busy2, done2, match2} !== 3'b000 || pi2 !== 4'h0 || tt2 !== 16'h0 || mism2 !== 5'd0) begin
      errors++;
      $display("FAIL reset_dut2: busy=%b done=%b pi=%h tt=%h mism=%0d expected 0",
               busy2, done2, pi2, tt2, mism2);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_pass;
    mode_zero = 1'b0;
    exp_tt0   = 16'hAAAA;
    start0    = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int e = 0; e < 16; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      checks++;
      if (pi0 !== 4'(e) || busy0 !== 1'b1 || done0 !== 1'b0) begin
        errors++;
        $display("FAIL pass_seq: after edge %0d pi=%h busy=%b done=%b expected pi=%h busy=1 done=0",
                 e, pi0, busy0, done0, 4'(e));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || pi0 !== 4'h0) begin
      errors++;
      $display("FAIL pass_done: done=%b busy=%b pi=%h expected done=1 busy=0 pi=0", done0, busy0, pi0);
    end
    checks++;
    if (tt0 !== 16'hAAAA || match0 !== 1'b1 || mism0 !== 5'd0) begin
      errors++;
      $display("FAIL pass_result: tt=%h match=%b mism=%0d expected tt=aaaa match=1 mism=0", tt0, match0, mism0);
    end
    @(posedge clk); #1;
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0 || tt0 !== 16'hAAAA || match0 !== 1'b1 || mism0 !== 5'd0) begin
      errors++;
      $display("FAIL pass_hold: done=%b busy=%b tt=%h match=%b mism=%0d expected idle holding aaaa/1/0",
               done0, busy0, tt0, match0, mism0);
    end
  endtask

  task automatic test_all_mismatch;
    int cyc;
    mode_zero = 1'b1;
    exp_tt0   = 16'hFFFF;
    start0    = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    checks++;
    if (match0 !== 1'b0 || tt0 !== 16'h0 || mism0 !== 5'd0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL mism_clear: match=%b tt=%h mism=%0d busy=%b expected 0/0/0/1", match0, tt0, mism0, busy0);
    end
    cyc = 0;
    while (done0 !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 16) begin
      errors++;
      $display("FAIL mism_latency: done after edge %0d expected 16", cyc);
    end
    checks++;
    if (tt0 !== 16'h0000 || mism0 !== 5'd16 || match0 !== 1'b0) begin
      errors++;
      $display("FAIL mism_result: tt=%h mism=%0d match=%b expected 0000/16/0", tt0, mism0, match0);
    end
    mode_zero = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lat2;
    exp_tt2 = 16'hFF00;
    start2  = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int e = 0; e < 48; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      checks++;
      if (pi2 !== 4'(e / 3) || busy2 !== 1'b1 || done2 !== 1'b0) begin
        errors++;
        $display("FAIL lat2_seq: after edge %0d pi=%h busy=%b done=%b expected pi=%h busy=1 done=0",
                 e, pi2, busy2, done2, 4'(e / 3));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL lat2_done: done=%b busy=%b expected done=1 busy=0 after edge 48", done2, busy2);
    end
    checks++;
    if (tt2 !== 16'hFF00 || match2 !== 1'b1 || mism2 !== 5'd0) begin
      errors++;
      $display("FAIL lat2_result: tt=%h match=%b mism=%0d expected ff00/1/0", tt2, match2, mism2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_filter;
    int cyc;
    mode_zero = 1'b0;
    do_sweep0(16'h5555, 16'h5555, 1'b1, cyc);
    checks++;
    if (cyc !== 16) begin
      errors++;
      $display("FAIL filt_latency: done after edge %0d expected 16", cyc);
    end
    checks++;
    if (tt0 !== 16'hAAAA || mism0 !== 5'd16 || match0 !== 1'b0) begin
      errors++;
      $display("FAIL filt_result: tt=%h mism=%0d match=%b expected aaaa/16/0", tt0, mism0, match0);
    end
    @(posedge clk); #1;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL filt_noqueue: busy=%b done=%b expected idle after done", busy0, done0);
    end
    @(posedge clk); #1;
    start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || tt0 !== 16'h0 || mism0 !== 5'd0 || match0 !== 1'b0) begin
      errors++;
      $display("FAIL filt_restart: busy=%b tt=%h mism=%0d match=%b expected 1/0000/0/0",
               busy0, tt0, mism0, match0);
    end
    cyc = 0;
    while (done0 !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 16) begin
      errors++;
      $display("FAIL filt_second: done after edge %0d expected 16", cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit saw_done;
    mode_zero = 1'b0;
    exp_tt0   = 16'h0000;
    start0    = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (tt0 !== 16'h000A || mism0 !== 5'd2) begin
      errors++;
      $display("FAIL rmid_partial: tt=%h mism=%0d expected 000a/2", tt0, mism0);
    end
    rst    = 1'b1;
    start0 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy0 !== 1'b0 || pi0 !== 4'h0 || tt0 !== 16'h0 || mism0 !== 5'd0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL rmid_state: busy=%b pi=%h tt=%h mism=%0d done=%b expected all 0",
               busy0, pi0, tt0, mism0, done0);
    end
    rst    = 1'b0;
    start0 = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done0 === 1'b1 || busy0 === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL rmid_nodone: activity seen after reset, expected none");
    end
    do_sweep0(16'hAAAA, 16'hAAAA, 1'b0, cyc);
    checks++;
    if (cyc !== 16 || tt0 !== 16'hAAAA || match0 !== 1'b1 || mism0 !== 5'd0) begin
      errors++;
      $display("FAIL rmid_resweep: edge=%0d tt=%h match=%b mism=%0d expected 16/aaaa/1/0",
               cyc, tt0, match0, mism0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exp_stable;
    int cyc;
    mode_zero = 1'b0;
    do_sweep0(16'hAAAA, 16'h0000, 1'b0, cyc);
    checks++;
    if (cyc !== 16 || match0 !== 1'b1 || mism0 !== 5'd0) begin
      errors++;
      $display("FAIL exp_stable_a: edge=%0d match=%b mism=%0d expected 16/1/0", cyc, match0, mism0);
    end
    @(posedge clk); #1;
    do_sweep0(16'h0000, 16'hAAAA, 1'b0, cyc);
    checks++;
    if (cyc !== 16 || match0 !== 1'b0 || mism0 !== 5'd8) begin
      errors++;
      $display("FAIL exp_stable_b: edge=%0d match=%b mism=%0d expected 16/0/8", cyc, match0, mism0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_all_mismatch();
    test_lat2();
    test_start_filter();
    test_reset_mid();
    test_exp_stable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
